// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage with programmable dead band and sticky brake.
// Each channel runs an independent FSM on a registered copy of its raw PWM level;
// gate drives are registered and decoded from the next state, so H and L can
// never be asserted together.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_OFF   | disabled / braked / just reset, both drives low
// ST_LOW   | low-side drive on
// ST_DT_LH | dead band between low-side off and high-side on
// ST_HIGH  | high-side drive on
// ST_DT_HL | dead band between high-side off and low-side on
module pwm_deadtime #(
    parameter int CHANNELS = 4,
    parameter int DT_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [DT_WIDTH-1:0] dt_i,
    input  logic [CHANNELS-1:0] pwm_i,
    input  logic                brk_i,
    input  logic                brk_clr_i,
    output logic [CHANNELS-1:0] pwm_h_o,
    output logic [CHANNELS-1:0] pwm_l_o,
    output logic                brk_o
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LOW   = 3'd1,
        ST_DT_LH = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DT_HL = 3'd4
    } state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] pwm_q;
    logic                kill;

    // A brake already latched, a brake arriving now, or a disabled stage all
    // force every channel to OFF on this edge.
    assign kill = brk_o | brk_i | ~en_i;

    // Input stage: register the raw PWM levels once.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) pwm_q <= '0;
        else          pwm_q <= pwm_i;
    end

    // Sticky brake flag; a set request outranks a simultaneous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)       brk_o <= 1'b0;
        else if (brk_i)     brk_o <= 1'b1;
        else if (brk_clr_i) brk_o <= 1'b0;
    end

    // Per-channel next state and dead-band counter.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (kill) begin
                state_d[i] = ST_OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_OFF, ST_LOW: begin
                        if (!pwm_q[i]) begin
                            state_d[i] = ST_LOW;
                        end else if (dt_i == '0) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = ST_DT_LH;
                            cnt_d[i]   = dt_i;
                        end
                    end
                    ST_DT_LH: begin
                        // A pulse shorter than the dead band is absorbed here.
                        if (!pwm_q[i]) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == DT_WIDTH'(1)) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (pwm_q[i]) begin
                            state_d[i] = ST_HIGH;
                        end else if (dt_i == '0) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = '0;
                        end else begin
                            state_d[i] = ST_DT_HL;
                            cnt_d[i]   = dt_i;
                        end
                    end
                    ST_DT_HL: begin
                        if (pwm_q[i]) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == DT_WIDTH'(1)) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // State, counter and gate-drive registers; drives decode from next state.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!rst_n_i) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
                pwm_h_o[i] <= 1'b0;
                pwm_l_o[i] <= 1'b0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                pwm_h_o[i] <= (state_d[i] == ST_HIGH);
                pwm_l_o[i] <= (state_d[i] == ST_LOW);
            end
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed scenarios plus a randomized run against a
// run-length reference model of the dead-band rules.
module tb_pwm_deadtime;
    localparam int CH = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n, en, brk, brk_clr;
    logic [DW-1:0] dt;
    logic [CH-1:0] pwm;
    logic [CH-1:0] h, l;
    logic          brk_o;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_deadtime #(.CHANNELS(CH), .DT_WIDTH(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .dt_i(dt), .pwm_i(pwm),
        .brk_i(brk), .brk_clr_i(brk_clr),
        .pwm_h_o(h), .pwm_l_o(l), .brk_o(brk_o)
    );

    always #5 clk = ~clk;

    // Reference model: a channel keeps driving the side it last drove while the
    // registered input agrees with it; once the input has disagreed for dt+1
    // consecutive live edges (dt taken when that run began) it switches sides.
    // Brake/disable/reset forget everything and leave the low side as "last".
    logic [CH-1:0] m_q, m_side, m_rq, m_h, m_l;
    int            m_run [CH];
    int            m_dtl [CH];
    logic          m_brk, m_kill;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q = '0; m_side = '0; m_rq = '0; m_h = '0; m_l = '0; m_brk = 1'b0;
            for (int i = 0; i < CH; i++) begin m_run[i] = 0; m_dtl[i] = 0; end
        end else begin
            m_kill = m_brk || brk || !en;
            for (int i = 0; i < CH; i++) begin
                if (m_kill) begin
                    m_run[i] = 0; m_side[i] = 1'b0; m_h[i] = 1'b0; m_l[i] = 1'b0;
                end else begin
                    if (m_run[i] == 0 || m_q[i] != m_rq[i]) begin
                        m_run[i] = 1; m_rq[i] = m_q[i]; m_dtl[i] = int'(dt);
                    end else if (m_run[i] < 100000) begin
                        m_run[i]++;
                    end
                    if (m_q[i] != m_side[i] && m_run[i] >= m_dtl[i] + 1) m_side[i] = m_q[i];
                    m_h[i] = (m_q[i] == m_side[i]) && m_side[i];
                    m_l[i] = (m_q[i] == m_side[i]) && !m_side[i];
                end
            end
            m_brk = brk ? 1'b1 : (brk_clr ? 1'b0 : m_brk);
            m_q   = pwm;
        end
    end

    // Shoot-through watch, every cycle of every test.
    always @(negedge clk) begin
        n_tests++;
        if ((h & l) !== '0) begin
            n_fail++;
            $display("FAIL overlap t=%0t h=%b l=%b", $time, h, l);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; dt = 8'd3; pwm = '0; brk = 1'b0; brk_clr = 1'b0;
        cycles(3);
        n_tests++;
        if (h !== '0 || l !== '0 || brk_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state h=%b l=%b brk=%b required 0000 0000 0", h, l, brk_o);
        end
        rst_n = 1'b1;
        cycles(2);
        n_tests++;
        if (l !== 4'hF || h !== '0) begin
            n_fail++;
            $display("FAIL reset_to_low h=%b l=%b required h=0000 l=1111", h, l);
        end
    endtask

    task automatic test_deadband();
        int d = 3;
        dt = DW'(d);
        cycles(4);
        pwm[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (h[0] !== (k >= d + 2) || l[0] !== (k < 2)) begin
                n_fail++;
                $display("FAIL deadband_rise k=%0d h=%b l=%b required h=%b l=%b",
                         k, h[0], l[0], k >= d + 2, k < 2);
            end
        end
        pwm[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (l[0] !== (k >= d + 2) || h[0] !== (k < 2)) begin
                n_fail++;
                $display("FAIL deadband_fall k=%0d h=%b l=%b required h=%b l=%b",
                         k, h[0], l[0], k < 2, k >= d + 2);
            end
        end
    endtask

    task automatic test_dt0();
        logic lvl = 1'b0;
        logic expv;
        dt = '0; pwm[1] = 1'b0;
        cycles(4);
        for (int t = 0; t < 6; t++) begin
            lvl = ~lvl;
            pwm[1] = lvl;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                expv = (k >= 2) ? lvl : ~lvl;
                n_tests++;
                if (h[1] !== expv || l[1] !== ~expv) begin
                    n_fail++;
                    $display("FAIL dt0_swap t=%0d k=%0d h=%b l=%b required h=%b l=%b",
                             t, k, h[1], l[1], expv, ~expv);
                end
            end
        end
    endtask

    task automatic test_glitch();
        dt = 8'd5; pwm[2] = 1'b0;
        cycles(6);
        pwm[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 2) pwm[2] = 1'b0;
            n_tests++;
            if (h[2] !== 1'b0 || l[2] !== !(k == 2 || k == 3)) begin
                n_fail++;
                $display("FAIL glitch_absorb k=%0d h=%b l=%b required h=0 l=%b",
                         k, h[2], l[2], !(k == 2 || k == 3));
            end
        end
    endtask

    task automatic test_brake();
        dt = 8'd2; pwm = 4'b0101;
        cycles(8);
        brk = 1'b1;
        @(negedge clk);
        brk = 1'b0;
        n_tests++;
        if (brk_o !== 1'b1 || h !== '0 || l !== '0) begin
            n_fail++;
            $display("FAIL brake_set brk=%b h=%b l=%b required 1 0000 0000", brk_o, h, l);
        end
        brk = 1'b1; brk_clr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (brk_o !== 1'b1) begin
            n_fail++;
            $display("FAIL brake_set_wins brk=%b required 1", brk_o);
        end
        brk = 1'b0;
        @(negedge clk);
        brk_clr = 1'b0;
        n_tests++;
        if (brk_o !== 1'b0 || h !== '0 || l !== '0) begin
            n_fail++;
            $display("FAIL brake_clear brk=%b h=%b l=%b required 0 0000 0000", brk_o, h, l);
        end
        @(negedge clk);
        n_tests++;
        if (h !== '0 || l !== 4'b1010) begin
            n_fail++;
            $display("FAIL brake_restart h=%b l=%b required 0000 1010", h, l);
        end
        cycles(2);
        n_tests++;
        if (h !== 4'b0101 || l !== 4'b1010) begin
            n_fail++;
            $display("FAIL brake_resume h=%b l=%b required 0101 1010", h, l);
        end
    endtask

    task automatic test_enable();
        dt = 8'd4; pwm = '0;
        cycles(8);
        pwm[3] = 1'b1;
        cycles(3);
        en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (h !== '0 || l !== '0) begin
            n_fail++;
            $display("FAIL enable_off h=%b l=%b required 0000 0000", h, l);
        end
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (h[3] !== (k >= 5) || l[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_restart k=%0d h=%b l=%b required h=%b l=0",
                         k, h[3], l[3], k >= 5);
            end
        end
    endtask

    task automatic test_reset_mid();
        dt = 8'd6; pwm = '0;
        cycles(10);
        pwm = 4'b0011;
        cycles(3);
        brk = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        brk = 1'b0;
        n_tests++;
        if (h !== '0 || l !== '0 || brk_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid h=%b l=%b brk=%b required 0000 0000 0", h, l, brk_o);
        end
        rst_n = 1'b1;
        cycles(12);
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_tests++;
            if (h !== m_h || l !== m_l || brk_o !== m_brk) begin
                n_fail++;
                $display("FAIL random c=%0d h=%b l=%b brk=%b required h=%b l=%b brk=%b",
                         c, h, l, brk_o, m_h, m_l, m_brk);
            end
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 5) == 0) pwm[i] = ~pwm[i];
            if ($urandom_range(0, 39) == 0) dt = DW'($urandom_range(0, 5));
            en      = ($urandom_range(0, 99) != 0);
            brk     = ($urandom_range(0, 299) == 0);
            brk_clr = ($urandom_range(0, 19) == 0);
        end
        en = 1'b1; brk = 1'b0; brk_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_deadband();
        test_dt0();
        test_glitch();
        test_brake();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
